switch_debouncer: RTL

- Two-channel debouncer for the board push-buttons SW1 and SW2.
- Sits directly upstream of the switch-to-LED decode logic, which consumes the clean levels produced here instead of the raw pins.
- Each channel has a 2-flop synchronizer, a stability counter FSM, a registered clean level, one-cycle rise/fall pulses and a press-toggle flag.
- Target clock is the 12 MHz board oscillator.

---
 rtl/switch_debouncer.sv | 132 +++++++++++++
 1 files changed

// File: rtl/switch_debouncer.sv
// Two-channel push-button debouncer: per channel a 2-flop synchronizer, a
// stability-count FSM, a registered clean level, rise/fall pulses and a toggle.

// state | meaning
// IDLE  | synchronized pin equals clean level, counter held at zero
// WAIT  | pin differs from clean level, counting consecutive stable cycles
module switch_debouncer_ch #(
  parameter int unsigned CNT_MAX = 240000
) (
  input  logic clk,
  input  logic rstn,
  input  logic pin,
  output logic db,
  output logic rise,
  output logic fall,
  output logic tog
);
  localparam int unsigned CNT_W = $clog2(CNT_MAX + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic             s0_q, s1_q;
  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             db_q, db_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             tog_q, tog_d;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0_q    <= 1'b0;
      s1_q    <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      db_q    <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      tog_q   <= 1'b0;
    end else begin
      s0_q    <= pin;
      s1_q    <= s0_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      db_q    <= db_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      tog_q   <= tog_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    db_d    = db_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    tog_d   = tog_q;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s1_q != db_q) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT: begin
        // a bounce back to the current level wins over a terminal count
        if (s1_q == db_q) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(CNT_MAX)) begin
          db_d    = ~db_q;
          rise_d  = ~db_q;
          fall_d  = db_q;
          tog_d   = tog_q ^ ~db_q;
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign db   = db_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign tog  = tog_q;
endmodule

module switch_debouncer #(
  parameter int unsigned CNT_MAX = 240000
) (
  input  logic clk,
  input  logic rstn,
  input  logic SW1,
  input  logic SW2,
  output logic SW1_DB,
  output logic SW2_DB,
  output logic SW1_RISE,
  output logic SW2_RISE,
  output logic SW1_FALL,
  output logic SW2_FALL,
  output logic SW1_TOG,
  output logic SW2_TOG
);
  switch_debouncer_ch #(.CNT_MAX(CNT_MAX)) u_ch1 (
    .clk (clk),
    .rstn(rstn),
    .pin (SW1),
    .db  (SW1_DB),
    .rise(SW1_RISE),
    .fall(SW1_FALL),
    .tog (SW1_TOG)
  );

  switch_debouncer_ch #(.CNT_MAX(CNT_MAX)) u_ch2 (
    .clk (clk),
    .rstn(rstn),
    .pin (SW2),
    .db  (SW2_DB),
    .rise(SW2_RISE),
    .fall(SW2_FALL),
    .tog (SW2_TOG)
  );
endmodule
